// File: rtl/main_fsm.sv
// main_fsm: multicycle processor control FSM (fetch/decode/memory/execute/branch).
// Moore decode of all control outputs from the current state; pcWrite combines
// the internal pcUpdate and branch strobes with the ALU zero flag.
// Memory-wait states (FETCH, MEMREAD, MEMWRITE) are guarded by an 8-bit wait
// counter that aborts back to FETCH after WAIT_MAX stalled cycles.
// Optional feature macro: MAIN_FSM_JAL_EN adds the JAL state and opcode 1101111;
// without it that opcode is reported as illegal.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction, PC+4; waits on memReady
// DECODE   | read registers, compute branch/jump target in ALU
// MEMADR   | compute load/store address
// MEMREAD  | load access; waits on memReady
// MEMWB    | write load data to register file
// MEMWRITE | store access; waits on memReady
// EXECR    | register-register ALU operation
// EXECI    | register-immediate ALU operation
// ALUWB    | write ALU result to register file
// BEQ      | compare for branch, PC <= target when zero
// JAL      | PC <= target, rd link value computed (MAIN_FSM_JAL_EN only)

module main_fsm #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       illegalOp,
    output logic       memTimeout
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [7:0] WAIT_LIMIT = WAIT_MAX[7:0];

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ
`ifdef MAIN_FSM_JAL_EN
        , JAL
`endif
    } state_t;

    state_t     state;
    logic [7:0] waitCnt;
    logic       waitState;
    logic       timeout;
    logic       opLegal;
    logic       pcUpdate;
    logic       branch;

    // Timeout fires only while stalled in a memory-wait state at the limit;
    // memReady arriving on that same cycle takes priority.
    always_comb begin
        waitState = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
        timeout   = waitState && !memReady && (waitCnt == WAIT_LIMIT);
    end

    // Opcodes that DECODE knows how to dispatch.
    always_comb begin
        opLegal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: opLegal = 1'b1;
`ifdef MAIN_FSM_JAL_EN
            OP_JAL:                                           opLegal = 1'b1;
`endif
            default:                                          opLegal = 1'b0;
        endcase
    end

    // State register and wait counter; any state change (including a FETCH
    // retry after timeout) leaves the counter cleared for the next wait state.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            if (waitState && !memReady && !timeout)
                waitCnt <= waitCnt + 8'd1;
            else
                waitCnt <= '0;

            case (state)
                FETCH: begin
                    if (memReady)
                        state <= DECODE;
                end
                DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_RTYPE:          state <= EXECR;
                        OP_ITYPE:          state <= EXECI;
                        OP_BRANCH:         state <= BEQ;
`ifdef MAIN_FSM_JAL_EN
                        OP_JAL:            state <= JAL;
`endif
                        default:           state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (op == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD: begin
                    if (memReady)
                        state <= MEMWB;
                    else if (timeout)
                        state <= FETCH;
                end
                MEMWB:    state <= FETCH;
                MEMWRITE: begin
                    if (memReady || timeout)
                        state <= FETCH;
                end
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
`ifdef MAIN_FSM_JAL_EN
                JAL:      state <= ALUWB;
`endif
                default:  state <= FETCH;
            endcase
        end
    end

    // Control decode from state; FETCH gates its writes with memReady so a
    // stalled or timed-out fetch never commits the IR or PC.
    always_comb begin
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = 2'b00;
        aluSrcA    = 2'b00;
        aluSrcB    = 2'b00;
        aluOp      = 2'b00;
        illegalOp  = 1'b0;
        pcUpdate   = 1'b0;
        branch     = 1'b0;
        memTimeout = timeout;
        case (state)
            FETCH: begin
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = memReady;
                pcUpdate  = memReady;
            end
            DECODE: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b01;
                illegalOp = !opLegal;
            end
            MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            MEMREAD: begin
                adrSrc = 1'b1;
            end
            MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
            end
            MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            EXECR: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b10;
            end
            EXECI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOp   = 2'b10;
            end
            ALUWB: begin
                regWrite = 1'b1;
            end
            BEQ: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MAIN_FSM_JAL_EN
            JAL: begin
                aluSrcA  = 2'b01;
                aluSrcB  = 2'b10;
                pcUpdate = 1'b1;
            end
`endif
            default: begin
                adrSrc = 1'b0;
            end
        endcase
    end

    assign pcWrite = pcUpdate | (branch & zero);

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed scenarios plus randomized traffic for main_fsm,
// checked cycle by cycle against an instruction-level plan model.
module tb_main_fsm;

    localparam int WMAX = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk;
    logic       resetN;
    logic [6:0] op;
    logic       zero;
    logic       memReady;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
    logic       illegalOp, memTimeout;

    int total = 0;
    int bad   = 0;

    main_fsm #(.WAIT_MAX(WMAX)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .op         (op),
        .zero       (zero),
        .memReady   (memReady),
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .aluOp      (aluOp),
        .illegalOp  (illegalOp),
        .memTimeout (memTimeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: the remaining phases of the current instruction; empty means fetching.
    typedef enum int {P_FETCH, P_DECODE, P_ADR, P_RD, P_MWB, P_WR, P_EXR, P_EXI, P_AWB, P_BEQ, P_JAL} phase_t;
    phase_t plan[$];
    int     waits = 0;

    // Observation vector bit positions.
    localparam int B_PCW = 14, B_ADR = 13, B_MW = 12, B_IRW = 11, B_RW = 10;
    localparam int B_ILL = 1, B_TO = 0;

    function automatic bit isLegal(input logic [6:0] o);
        bit ok;
        ok = (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR);
`ifdef MAIN_FSM_JAL_EN
        ok = ok || (o == JL);
`endif
        return ok;
    endfunction

    function automatic phase_t curPhase();
        return (plan.size() == 0) ? P_FETCH : plan[0];
    endfunction

    function automatic logic [14:0] expOut(input phase_t p, input logic [6:0] o,
                                           input logic z, input logic rdy);
        logic pcw, adr, mw, irw, rw, ill, to;
        logic [1:0] rs, sa, sb, ao;
        {pcw, adr, mw, irw, rw, ill, to} = '0;
        {rs, sa, sb, ao} = '0;
        case (p)
            P_FETCH:  begin sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; to = !rdy && (waits == WMAX); end
            P_DECODE: begin sa = 2'b01; sb = 2'b01; ill = !isLegal(o); end
            P_ADR:    begin sa = 2'b10; sb = 2'b01; end
            P_RD:     begin adr = 1'b1; to = !rdy && (waits == WMAX); end
            P_MWB:    begin rs = 2'b01; rw = 1'b1; end
            P_WR:     begin adr = 1'b1; mw = 1'b1; to = !rdy && (waits == WMAX); end
            P_EXR:    begin sa = 2'b10; ao = 2'b10; end
            P_EXI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            P_AWB:    begin rw = 1'b1; end
            P_BEQ:    begin sa = 2'b10; ao = 2'b01; pcw = z; end
            P_JAL:    begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            default:  begin rs = 2'b00; end
        endcase
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ao, ill, to};
    endfunction

    task automatic modelAdvance(input logic rst, input logic [6:0] o, input logic rdy);
        phase_t p;
        p = curPhase();
        if (!rst) begin
            plan.delete();
            waits = 0;
        end else if (p == P_FETCH || p == P_RD || p == P_WR) begin
            if (rdy) begin
                waits = 0;
                if (p == P_FETCH) plan.push_back(P_DECODE);
                else void'(plan.pop_front());
            end else if (waits == WMAX) begin
                waits = 0;
                plan.delete();
            end else begin
                waits++;
            end
        end else if (p == P_DECODE) begin
            if      (o == LW) plan = '{P_ADR, P_RD, P_MWB};
            else if (o == SW) plan = '{P_ADR, P_WR};
            else if (o == RT) plan = '{P_EXR, P_AWB};
            else if (o == IT) plan = '{P_EXI, P_AWB};
            else if (o == BR) plan = '{P_BEQ};
            else if (o == JL && isLegal(o)) plan = '{P_JAL, P_AWB};
            else plan.delete();
        end else begin
            void'(plan.pop_front());
        end
    endtask

    // One clock: drive inputs after the falling edge, sample, then advance the model.
    task automatic step(input logic rst, input logic [6:0] o, input logic z, input logic rdy,
                        output logic [14:0] obs, output logic [14:0] expv);
        @(negedge clk);
        resetN   = rst;
        op       = o;
        zero     = z;
        memReady = rdy;
        #1;
        obs  = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB, aluOp, illegalOp, memTimeout};
        expv = expOut(curPhase(), o, z, rdy);
        @(posedge clk);
        modelAdvance(rst, o, rdy);
    endtask

    task automatic test_reset();
        logic [14:0] obs, expv;
        step(1'b0, BAD, 1'b0, 1'b1, obs, expv);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, BAD, 1'b1, i[0], obs, expv);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reset cyc%0d: got %b want %b", i, obs, expv);
            end
            total++;
            if (obs[B_IRW] !== i[0] || obs[B_PCW] !== i[0] || obs[B_MW] !== 1'b0 || obs[B_TO] !== 1'b0) begin
                bad++;
                $display("FAIL reset_fetch_decode cyc%0d: got %b want irWrite=pcWrite=%0d", i, obs, i[0]);
            end
        end
    endtask

    task automatic test_lw();
        logic [14:0] obs, expv;
        int rwCnt;
        rwCnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, LW, 1'b0, 1'b1, obs, expv);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL lw cyc%0d: got %b want %b", i, obs, expv);
            end
            if (obs[B_RW] === 1'b1) begin
                rwCnt++;
                total++;
                if (obs[9:8] !== 2'b01 || i != 4) begin
                    bad++;
                    $display("FAIL lw_writeback cyc%0d: got resultSrc=%b want 01 in cycle 4", i, obs[9:8]);
                end
            end
        end
        total++;
        if (rwCnt != 1) begin
            bad++;
            $display("FAIL lw_regwrite_count: got %0d want 1", rwCnt);
        end
    endtask

    task automatic test_sw_wait();
        logic [14:0] obs, expv;
        int mwCnt, rwCnt;
        mwCnt = 0;
        rwCnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, SW, 1'b0, (i < 3) || (i == 6), obs, expv);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL sw cyc%0d: got %b want %b", i, obs, expv);
            end
            if (obs[B_MW] === 1'b1) mwCnt++;
            if (obs[B_RW] === 1'b1) rwCnt++;
        end
        total++;
        if (mwCnt != 4 || rwCnt != 0) begin
            bad++;
            $display("FAIL sw_counts: got memWrite=%0d regWrite=%0d want 4 and 0", mwCnt, rwCnt);
        end
    endtask

    task automatic test_beq();
        logic [14:0] obs, expv;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b1, BR, (pass == 0), 1'b1, obs, expv);
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL beq p%0d cyc%0d: got %b want %b", pass, i, obs, expv);
                end
            end
            total++;
            if (obs[B_PCW] !== (pass == 0) || obs[3:2] !== 2'b01) begin
                bad++;
                $display("FAIL beq_pcwrite p%0d: got pcWrite=%b aluOp=%b want %0d and 01", pass, obs[B_PCW], obs[3:2], pass == 0);
            end
        end
    endtask

    task automatic test_illegal();
        logic [14:0] obs, expv;
        for (int i = 0; i < 3; i++) begin
            step(i != 2, BAD, 1'b0, 1'b1, obs, expv);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL illegal cyc%0d: got %b want %b", i, obs, expv);
            end
            total++;
            if (obs[B_ILL] !== (i == 1) || (i == 2 && obs[B_IRW] !== 1'b1)) begin
                bad++;
                $display("FAIL illegal_pulse cyc%0d: got illegalOp=%b irWrite=%b", i, obs[B_ILL], obs[B_IRW]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [14:0] obs, expv;
        int toCnt;
        toCnt = 0;
        // fetch stalls twice into timeout, then a load whose read times out
        for (int i = 0; i < 18; i++) begin
            step(1'b1, LW, 1'b0, (i == 10) || (i == 11) || (i == 12), obs, expv);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL timeout cyc%0d: got %b want %b", i, obs, expv);
            end
            if (obs[B_TO] === 1'b1) begin
                toCnt++;
                total++;
                if (!(i == 4 || i == 9 || i == 17) || obs[B_IRW] !== 1'b0 || obs[B_RW] !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_pulse cyc%0d: got %b want pulse only at 4/9/17", i, obs);
                end
            end
        end
        total++;
        if (toCnt != 3) begin
            bad++;
            $display("FAIL timeout_count: got %0d want 3", toCnt);
        end
    endtask

    task automatic test_ready_wins();
        logic [14:0] obs, expv;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, LW, 1'b0, (i < 3) || (i >= 7), obs, expv);
            total++;
            if (obs !== expv || obs[B_TO] !== 1'b0) begin
                bad++;
                $display("FAIL ready_wins cyc%0d: got %b want %b", i, obs, expv);
            end
        end
        total++;
        if (obs[B_RW] !== 1'b1 || obs[9:8] !== 2'b01) begin
            bad++;
            $display("FAIL ready_wins_wb: got regWrite=%b resultSrc=%b want 1 and 01", obs[B_RW], obs[9:8]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [14:0] obs, expv;
        for (int i = 0; i < 6; i++) begin
            step(i != 4, SW, 1'b0, i < 3, obs, expv);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reset_write cyc%0d: got %b want %b", i, obs, expv);
            end
        end
        total++;
        if (obs[B_MW] !== 1'b0 || obs[B_ADR] !== 1'b0 || obs[5:4] !== 2'b10) begin
            bad++;
            $display("FAIL reset_write_fetch: got %b want memWrite 0, adrSrc 0, aluSrcB 10", obs);
        end
    endtask

    task automatic test_jal_opcode();
        logic [14:0] obs, expv;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, JL, 1'b0, 1'b1, obs, expv);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL jal cyc%0d: got %b want %b", i, obs, expv);
            end
            if (i == 1) begin
                total++;
`ifdef MAIN_FSM_JAL_EN
                if (obs[B_ILL] !== 1'b0) begin
`else
                if (obs[B_ILL] !== 1'b1) begin
`endif
                    bad++;
                    $display("FAIL jal_decode: got illegalOp=%b", obs[B_ILL]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [14:0] obs, expv;
        logic [6:0]  curOp;
        logic [6:0]  pool [7];
        logic        rst;
        pool  = '{LW, SW, RT, IT, BR, JL, BAD};
        curOp = LW;
        for (int i = 0; i < 800; i++) begin
            if (curPhase() == P_FETCH) begin
                if ($urandom_range(0, 7) == 0) curOp = 7'($urandom);
                else curOp = pool[$urandom_range(0, 6)];
            end
            rst = ($urandom_range(0, 59) != 0);
            step(rst, curOp, 1'($urandom), ($urandom_range(0, 2) != 0), obs, expv);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random cyc%0d op=%b: got %b want %b", i, curOp, obs, expv);
            end
        end
    endtask

    initial begin
        resetN   = 1'b0;
        op       = '0;
        zero     = 1'b0;
        memReady = 1'b0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_ready_wins();
        test_reset_mid_write();
        test_jal_opcode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
